// File: rtl/arb_pkg.sv
// Shared types and widths for the round-robin arbiter slice.
package arb_pkg;

  localparam int unsigned NREQ  = 32;
  localparam int unsigned ID_W  = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} arb_state_t;
  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/ffo32.sv
// 32-bit find-first-one encoder: y_o is the index of the highest set bit, v_o flags any bit set.
module ffo32
  import arb_pkg::*;
(
  input  logic [31:0] d_i,
  output req_id_t     y_o,
  output logic        v_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    y_o = '0;
    for (int i = 0; i < 32; i++) begin
      if (d_i[i]) y_o = ID_W'(i);
    end
  end

  assign v_o = |d_i;

endmodule

// File: rtl/rr_mask_gen.sv
// Thermometer mask: bit i set iff i < last_id_i, so priority rotates below the last owner.
module rr_mask_gen
  import arb_pkg::*;
(
  input  req_id_t     last_id_i,
  output logic [31:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < 32; i++) begin
      mask_o[i] = (ID_W'(i) < last_id_i);
    end
  end

endmodule

// File: rtl/ffo_rr_arbiter.sv
// Round-robin arbiter for 32 requesters: valid/ready grant offer, then ownership until release.
// Optional forced release after TIMEOUT_CYC busy cycles when ARB_TIMEOUT_EN is defined.
module ffo_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ        = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_i,
  output logic        gnt_valid_o,
  input  logic        gnt_ready_i,
  output req_id_t     gnt_id_o,
  output logic [31:0] gnt_onehot_o,
  output logic        busy_o,
  input  logic        release_i,
  output logic        timeout_o
);

  if (NREQ != 32) begin : g_nreq_chk
    $error("ffo_rr_arbiter: only NREQ=32 is supported");
  end

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_tmo_chk
    $error("ffo_rr_arbiter: TIMEOUT_CYC must be within 2..65535");
  end

  arb_state_t  state_q;
  logic        gnt_valid_q;
  req_id_t     gnt_id_q;
  logic [31:0] gnt_onehot_q;
  logic        busy_q;
  logic        timeout_q;
  req_id_t     last_id_q;

  logic [31:0] mask_c;
  logic [31:0] req_masked_c;
  req_id_t     masked_id_c;
  req_id_t     raw_id_c;
  logic        masked_v_c;
  logic        raw_v_c;
  req_id_t     winner_c;

  rr_mask_gen u_mask (
    .last_id_i (last_id_q),
    .mask_o    (mask_c)
  );

  assign req_masked_c = req_i & mask_c;

  ffo32 u_ffo_masked (
    .d_i (req_masked_c),
    .y_o (masked_id_c),
    .v_o (masked_v_c)
  );

  ffo32 u_ffo_raw (
    .d_i (req_i),
    .y_o (raw_id_c),
    .v_o (raw_v_c)
  );

  // Masked requests below the last owner take precedence; otherwise wrap to the raw vector.
  assign winner_c = masked_v_c ? masked_id_c : raw_id_c;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      gnt_onehot_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      last_id_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (raw_v_c) begin
            state_q      <= GRANT;
            gnt_valid_q  <= 1'b1;
            gnt_id_q     <= winner_c;
            gnt_onehot_q <= 32'(1) << winner_c;
          end
        end
        GRANT: begin
          // Accept has priority over a withdrawal in the same cycle.
          if (gnt_ready_i) begin
            state_q     <= BUSY;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            last_id_q   <= gnt_id_q;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else if (!req_i[gnt_id_q]) begin
            state_q      <= IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
          end
        end
        BUSY: begin
          if (release_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            gnt_onehot_q <= '0;
`ifdef ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q      <= IDLE;
          gnt_valid_q  <= 1'b0;
          gnt_onehot_q <= '0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_valid_o  = gnt_valid_q;
  assign gnt_id_o     = gnt_id_q;
  assign gnt_onehot_o = gnt_onehot_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule
